// File: rtl/commit_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer_if
//   Bundles the commit-stage retire lanes and the outgoing valid/ready trace
//   record stream of commit_trace_buffer.
//   Parameters:
//     COMMIT_WIDTH  number of retire lanes (lane 0 oldest)
//     CYC_W         timestamp width
//   Modports:
//     master  commit-stage / trace-consumer side (drives commits and ready)
//     slave   the trace buffer (receives commits, drives the record stream)
// -----------------------------------------------------------------------------
interface commit_trace_buffer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CYC_W        = 64
);
  // commit lanes
  logic [COMMIT_WIDTH-1:0]    commit_valid;
  logic [32*COMMIT_WIDTH-1:0] commit_pc;
  logic [32*COMMIT_WIDTH-1:0] commit_inst;
  logic [6*COMMIT_WIDTH-1:0]  commit_Ard;
  logic [32*COMMIT_WIDTH-1:0] commit_data;
  logic [COMMIT_WIDTH-1:0]    st_commit;
  logic [32*COMMIT_WIDTH-1:0] st_addr;
  logic [32*COMMIT_WIDTH-1:0] st_data;
  // record stream
  logic                       trace_valid;
  logic                       trace_ready;
  logic                       trace_kind;
  logic [31:0]                trace_pc;
  logic [31:0]                trace_inst;
  logic [5:0]                 trace_rd;
  logic [31:0]                trace_addr;
  logic [31:0]                trace_data;
  logic [CYC_W-1:0]           trace_cycle;

  modport master (
    output commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
    output st_commit, st_addr, st_data, trace_ready,
    input  trace_valid, trace_kind, trace_pc, trace_inst, trace_rd,
    input  trace_addr, trace_data, trace_cycle
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
    input  st_commit, st_addr, st_data, trace_ready,
    output trace_valid, trace_kind, trace_pc, trace_inst, trace_rd,
    output trace_addr, trace_data, trace_cycle
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//   Multi-lane commit trace capture. Each cycle up to COMMIT_WIDTH retirements
//   are filtered (PC >= PC_MIN, stores or non-branch register writes), store
//   data is aligned/masked, and qualifying records are compacted in lane order
//   into a DEPTH-entry FIFO drained one record per valid/ready handshake.
//   Records that do not fit are counted (saturating) and flagged (sticky).
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     bus (slave)     commit lanes in, trace record stream out
//     trace_clr       synchronous clear of drop_count / overflow
//     occupancy       entries held
//     drop_count      records lost to overflow (saturating)
//     overflow        sticky drop flag
//   Optional feature macro TRACE_TIMESTAMP_EN: when defined, a free-running
//   cycle counter timestamps each record and drives trace_cycle; otherwise
//   trace_cycle is tied to zero and no counter/timestamp storage exists.
//   DEPTH must be a power of two, at least 2 and at least COMMIT_WIDTH.
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int          COMMIT_WIDTH = 2,
  parameter int          DEPTH        = 16,
  parameter logic [31:0] PC_MIN       = 32'h0000_2000,
  parameter int          CYC_W        = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  commit_trace_buffer_if.slave      bus,
  input  logic                      trace_clr,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [31:0]               drop_count,
  output logic                      overflow
);
  localparam int             PW      = $clog2(DEPTH);
  localparam logic [PW:0]    DEPTH_V = (PW+1)'(DEPTH);
  localparam logic [PW:0]    ONE_V   = (PW+1)'(1);
  localparam logic [PW:0]    ZERO_V  = {(PW+1){1'b0}};

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  // Align store data to byte 0 and keep the access width given by funct3.
  function automatic logic [31:0] fmt_store(input logic [31:0] raw,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  return {24'h00_0000, sh[7:0]};
      3'b001:  return {16'h0000, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // A lane is traced if it retires above PC_MIN and is a store or a
  // register write that is not a conditional branch.
  function automatic logic lane_qual(input logic        vld,
                                     input logic [31:0] pc,
                                     input logic [31:0] inst,
                                     input logic [5:0]  rd,
                                     input logic        st);
    return vld && (pc >= PC_MIN) &&
           (st || ((rd != 6'd0) && (inst[6:2] != 5'b11000)));
  endfunction

  // Store takes precedence over register write when both apply.
  function automatic rec_t make_rec(input logic [31:0] pc,
                                    input logic [31:0] inst,
                                    input logic [5:0]  rd,
                                    input logic [31:0] cdata,
                                    input logic        st,
                                    input logic [31:0] saddr,
                                    input logic [31:0] sdata);
    rec_t r;
    r.kind = st;
    r.pc   = pc;
    r.inst = inst;
    r.rd   = st ? 6'd0 : rd;
    r.addr = st ? saddr : 32'h0000_0000;
    r.data = st ? fmt_store(sdata, saddr[1:0], inst[14:12]) : cdata;
    return r;
  endfunction

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic [31:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic [PW:0]   free_s;
  logic [PW:0]   acc_s;
  logic [PW:0]   drop_n_s;
  logic [PW-1:0] slot_s;
  logic          pop_s;
  logic [32:0]   drop_sum_s;

`ifdef TRACE_TIMESTAMP_EN
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] ts_q [DEPTH];
  logic [CYC_W-1:0] ts_d [DEPTH];
`endif

  // Next-state: compaction of qualifying lanes, drop accounting, pointers.
  always_comb begin
    mem_d      = mem_q;
`ifdef TRACE_TIMESTAMP_EN
    ts_d       = ts_q;
    cyc_d      = cyc_q + CYC_ONE;
`endif
    // Free space is taken before this cycle's pop: a pop never makes room
    // for a same-cycle enqueue.
    free_s     = DEPTH_V - occ_q;
    acc_s      = ZERO_V;
    drop_n_s   = ZERO_V;
    slot_s     = wr_ptr_q;
    pop_s      = (occ_q != ZERO_V) && bus.trace_ready;

    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (lane_qual(bus.commit_valid[l], bus.commit_pc[32*l +: 32],
                    bus.commit_inst[32*l +: 32], bus.commit_Ard[6*l +: 6],
                    bus.st_commit[l])) begin
        if (acc_s < free_s) begin
          slot_s        = wr_ptr_q + acc_s[PW-1:0];
          mem_d[slot_s] = make_rec(bus.commit_pc[32*l +: 32],
                                   bus.commit_inst[32*l +: 32],
                                   bus.commit_Ard[6*l +: 6],
                                   bus.commit_data[32*l +: 32],
                                   bus.st_commit[l],
                                   bus.st_addr[32*l +: 32],
                                   bus.st_data[32*l +: 32]);
`ifdef TRACE_TIMESTAMP_EN
          ts_d[slot_s]  = cyc_q;
`endif
          acc_s         = acc_s + ONE_V;
        end else begin
          drop_n_s      = drop_n_s + ONE_V;
        end
      end else begin
        acc_s = acc_s;
      end
    end

    wr_ptr_d   = wr_ptr_q + acc_s[PW-1:0];
    rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, pop_s};
    occ_d      = occ_q + acc_s - {{PW{1'b0}}, pop_s};

    drop_sum_s = {1'b0, drop_q} + 33'(drop_n_s);
    // A clear in the same cycle as a drop wins; the drop is not recorded.
    if (trace_clr) begin
      drop_d = 32'h0000_0000;
      ovf_d  = 1'b0;
    end else if (drop_n_s != ZERO_V) begin
      drop_d = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
      ovf_d  = 1'b1;
    end else begin
      drop_d = drop_q;
      ovf_d  = ovf_q;
    end
  end

  // State registers; entries are cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      occ_q    <= ZERO_V;
      drop_q   <= 32'h0000_0000;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Cycle counter and per-entry timestamps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= {CYC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ts_q[i] <= {CYC_W{1'b0}};
      end
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign bus.trace_cycle = ts_q[rd_ptr_q];
`else
  assign bus.trace_cycle = {CYC_W{1'b0}};
`endif

  // Head record comes straight from stored entries; no input-to-output path.
  assign bus.trace_valid = (occ_q != ZERO_V);
  assign bus.trace_kind  = mem_q[rd_ptr_q].kind;
  assign bus.trace_pc    = mem_q[rd_ptr_q].pc;
  assign bus.trace_inst  = mem_q[rd_ptr_q].inst;
  assign bus.trace_rd    = mem_q[rd_ptr_q].rd;
  assign bus.trace_addr  = mem_q[rd_ptr_q].addr;
  assign bus.trace_data  = mem_q[rd_ptr_q].data;
  assign occupancy       = occ_q;
  assign drop_count      = drop_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//   Directed bench for commit_trace_buffer (COMMIT_WIDTH=2, DEPTH=16). A
//   queue-based reference model tracks the expected FIFO contents, drop count
//   and overflow flag; a compare process checks the DUT against it on every
//   falling edge, and directed steps pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;
  localparam int CW    = 2;
  localparam int DEPTH = 16;
  localparam int CYC_W = 64;

  logic        clk;
  logic        rst;
  logic        trace_clr;
  logic [4:0]  occupancy;
  logic [31:0] drop_count;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  commit_trace_buffer_if #(.COMMIT_WIDTH(CW), .CYC_W(CYC_W)) bus ();

  commit_trace_buffer #(
    .COMMIT_WIDTH(CW), .DEPTH(DEPTH), .PC_MIN(32'h0000_2000), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .trace_clr(trace_clr),
    .occupancy(occupancy), .drop_count(drop_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        kind;
    logic [31:0] pc, inst, addr, data;
    logic [5:0]  rd;
    logic [63:0] cyc;
  } mrec_t;

  mrec_t   mq[$];
  longint  m_drop = 0;
  bit      m_ovf  = 1'b0;
  longint  m_cyc  = 0;

  function automatic logic [31:0] m_store(input logic [31:0] raw, input logic [31:0] a,
                                          input logic [2:0] f3);
    logic [31:0] v;
    v = raw >> (8 * a[1:0]);
    if (f3 == 3'd0)      return v & 32'h0000_00FF;
    else if (f3 == 3'd1) return v & 32'h0000_FFFF;
    else                 return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      m_cyc  = 0;
    end else begin
      int     fr;
      int     nd;
      mrec_t  e;
      logic [31:0] pc, inst;
      logic [5:0]  rd;
      fr = DEPTH - mq.size();
      nd = 0;
      if (mq.size() != 0 && bus.trace_ready) void'(mq.pop_front());
      for (int l = 0; l < CW; l++) begin
        pc   = bus.commit_pc[32*l +: 32];
        inst = bus.commit_inst[32*l +: 32];
        rd   = bus.commit_Ard[6*l +: 6];
        if (bus.commit_valid[l] && pc >= 32'h2000 &&
            (bus.st_commit[l] || (rd != 0 && inst[6:2] != 5'b11000))) begin
          if (fr > 0) begin
            fr--;
            e.kind = bus.st_commit[l];
            e.pc   = pc;
            e.inst = inst;
            e.rd   = e.kind ? 6'd0 : rd;
            e.addr = e.kind ? bus.st_addr[32*l +: 32] : 32'd0;
            e.data = e.kind ? m_store(bus.st_data[32*l +: 32], bus.st_addr[32*l +: 32], inst[14:12])
                            : bus.commit_data[32*l +: 32];
`ifdef TRACE_TIMESTAMP_EN
            e.cyc  = 64'(m_cyc);
`else
            e.cyc  = 64'd0;
`endif
            mq.push_back(e);
          end else begin
            nd++;
          end
        end
      end
      if (trace_clr) begin
        m_drop = 0;
        m_ovf  = 1'b0;
      end else if (nd > 0) begin
        m_drop = (m_drop + nd > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : m_drop + nd;
        m_ovf  = 1'b1;
      end
      m_cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_valid", bus.trace_valid, mq.size() != 0);
      check("cmp_occ", occupancy, mq.size());
      check("cmp_drop", drop_count, m_drop);
      check("cmp_ovf", overflow, m_ovf);
      if (mq.size() != 0) begin
        check("cmp_kind", bus.trace_kind, mq[0].kind);
        check("cmp_pc", bus.trace_pc, mq[0].pc);
        check("cmp_inst", bus.trace_inst, mq[0].inst);
        check("cmp_rd", bus.trace_rd, mq[0].rd);
        check("cmp_addr", bus.trace_addr, mq[0].addr);
        check("cmp_data", bus.trace_data, mq[0].data);
        check("cmp_cycle", bus.trace_cycle, mq[0].cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_lanes();
    bus.commit_valid = '0; bus.commit_pc = '0; bus.commit_inst = '0;
    bus.commit_Ard = '0; bus.commit_data = '0; bus.st_commit = '0;
    bus.st_addr = '0; bus.st_data = '0;
  endtask

  task automatic set_reg(input int l, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [5:0] rd, input logic [31:0] d);
    bus.commit_valid[l] = 1'b1; bus.st_commit[l] = 1'b0;
    bus.commit_pc[32*l +: 32] = pc; bus.commit_inst[32*l +: 32] = inst;
    bus.commit_Ard[6*l +: 6] = rd; bus.commit_data[32*l +: 32] = d;
  endtask

  task automatic set_st(input int l, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [5:0] rd, input logic [31:0] d);
    set_reg(l, pc, inst, rd, d);
    bus.st_commit[l] = 1'b1;
    bus.st_addr[32*l +: 32] = a; bus.st_data[32*l +: 32] = sd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; trace_clr = 1'b0; bus.trace_ready = 1'b0;
    clear_lanes();
    repeat (2) @(negedge clk);
    check("rst_valid", bus.trace_valid, 1'b0);
    check("rst_occ", occupancy, 5'd0);
    check("rst_drop", drop_count, 32'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_pc", bus.trace_pc, 32'd0);
    rst = 1'b0;

    // single register write, consumer ready
    bus.trace_ready = 1'b1;
    set_reg(0, 32'h2004, 32'h0050_0093, 6'd1, 32'h5);
    step(); clear_lanes();
    check("t1_valid", bus.trace_valid, 1'b1);
    check("t1_kind", bus.trace_kind, 1'b0);
    check("t1_rd", bus.trace_rd, 6'd1);
    check("t1_data", bus.trace_data, 32'h0000_0005);
    check("t1_pc", bus.trace_pc, 32'h2004);
    step();
    check("t1_gone", bus.trace_valid, 1'b0);

    // two stores in one cycle, consumer stalled
    bus.trace_ready = 1'b0;
    set_st(0, 32'h2010, 32'h00a0_8023, 32'h1003, 32'hAB00_0000, 6'd5, 32'hDEAD_BEEF);
    set_st(1, 32'h2014, 32'h00a0_9023, 32'h1002, 32'h1234_0000, 6'd0, 32'd0);
    step(); clear_lanes();
    check("t2_occ", occupancy, 5'd2);
    check("t2_kind", bus.trace_kind, 1'b1);
    check("t2_addr0", bus.trace_addr, 32'h1003);
    check("t2_data0", bus.trace_data, 32'h0000_00AB);
    check("t2_rd0", bus.trace_rd, 6'd0);
    bus.trace_ready = 1'b1;
    step();
    check("t2_data1", bus.trace_data, 32'h0000_1234);
    check("t2_addr1", bus.trace_addr, 32'h1002);
    step();
    check("t2_empty", bus.trace_valid, 1'b0);
    bus.trace_ready = 1'b0;

    // filtering
    set_reg(0, 32'h1FFC, 32'h0050_0093, 6'd1, 32'h7);
    set_reg(1, 32'h2008, 32'h0010_0013, 6'd0, 32'h9);
    step(); clear_lanes();
    check("t3_lowpc_rd0", occupancy, 5'd0);
    set_reg(0, 32'h2000, 32'h0020_8463, 6'd3, 32'h1);
    set_st(1, 32'h1FF0, 32'h00a0_8023, 32'h1000, 32'h55, 6'd0, 32'd0);
    step(); clear_lanes();
    check("t3_branch_lowst", occupancy, 5'd0);
    set_reg(0, 32'h2000, 32'h0050_0093, 6'd4, 32'h3);
    bus.commit_valid[0] = 1'b0;
    set_reg(1, 32'h2000, 32'h0050_0093, 6'd2, 32'h4);
    step(); clear_lanes();
    check("t3_boundary_occ", occupancy, 5'd1);
    check("t3_boundary_rd", bus.trace_rd, 6'd2);
    bus.trace_ready = 1'b1;
    step();
    bus.trace_ready = 1'b0;

    // overflow
    for (int i = 0; i < 7; i++) begin
      set_reg(0, 32'h2100 + 32'(8*i), 32'h0050_0093, 6'd1, 32'(i));
      set_reg(1, 32'h2104 + 32'(8*i), 32'h0050_0093, 6'd2, 32'(100 + i));
      step();
    end
    clear_lanes();
    set_reg(0, 32'h2200, 32'h0050_0093, 6'd3, 32'h77);
    step(); clear_lanes();
    check("t4_occ15", occupancy, 5'd15);
    set_reg(0, 32'h3000, 32'h0050_0093, 6'd1, 32'h1);
    set_reg(1, 32'h3004, 32'h0050_0093, 6'd2, 32'h2);
    step(); clear_lanes();
    check("t4_occ16", occupancy, 5'd16);
    check("t4_drop1", drop_count, 32'd1);
    check("t4_ovf", overflow, 1'b1);
    bus.trace_ready = 1'b1;
    set_reg(0, 32'h3008, 32'h0050_0093, 6'd1, 32'h3);
    set_reg(1, 32'h300C, 32'h0050_0093, 6'd2, 32'h4);
    step(); clear_lanes();
    bus.trace_ready = 1'b0;
    check("t4_pop_nospace_occ", occupancy, 5'd15);
    check("t4_drop3", drop_count, 32'd3);
    trace_clr = 1'b1;
    set_reg(0, 32'h3010, 32'h0050_0093, 6'd1, 32'h5);
    set_reg(1, 32'h3014, 32'h0050_0093, 6'd2, 32'h6);
    step(); clear_lanes();
    trace_clr = 1'b0;
    check("t4_clr_drop", drop_count, 32'd0);
    check("t4_clr_ovf", overflow, 1'b0);
    check("t4_clr_occ", occupancy, 5'd16);
    bus.trace_ready = 1'b1;
    repeat (16) step();
    check("t4_drained", bus.trace_valid, 1'b0);

    // backpressure with continuous commits
    for (int i = 0; i < 12; i++) begin
      bus.trace_ready = (i % 2 == 0);
      set_reg(0, 32'h4000 + 32'(4*i), 32'h0050_0093, 6'(1 + i), 32'(1000 + i));
      step();
    end
    clear_lanes();
    bus.trace_ready = 1'b1;
    repeat (10) step();
    check("t5_drained", bus.trace_valid, 1'b0);
    check("t5_nodrop", drop_count, 32'd0);

    // async reset mid-drain
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_reg(0, 32'h5000 + 32'(4*i), 32'h0050_0093, 6'd7, 32'(i));
      step();
    end
    clear_lanes();
    check("t6_occ5", occupancy, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", bus.trace_valid, 1'b0);
    check("t6_async_occ", occupancy, 5'd0);
    check("t6_async_drop", drop_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    set_reg(0, 32'h6000, 32'h0050_0093, 6'd9, 32'h99);
    step(); clear_lanes();
    check("t6_post_valid", bus.trace_valid, 1'b1);
`ifdef TRACE_TIMESTAMP_EN
    check("t6_cycle", bus.trace_cycle, 64'd3);
`else
    check("t6_cycle", bus.trace_cycle, 64'd0);
`endif
    bus.trace_ready = 1'b1;
    step();
    check("t6_empty", bus.trace_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
